// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared types for the conway system sequencer
package conway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DRAIN  = 3'd4
    } seq_state_t;

    // States in which one grid bit per cycle moves through the memory port
    function automatic logic is_transfer(input seq_state_t s);
        return (s == ST_LOAD) || (s == ST_OUTPUT);
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - loadable up-counter with terminal-count flag
module cycle_counter #(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable)
            count <= count + WIDTH'(1);
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/system_sequencer.sv
// rtl/system_sequencer.sv - command sequencer for the conway grid memory
module system_sequencer
    import conway_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int GEN_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_LOAD,
    input  logic                 CMD_RUN,
    input  logic                 CMD_OUTPUT,
    input  logic                 CMD_ABORT,
    input  logic [GEN_WIDTH-1:0] GEN_COUNT,
    output logic                 LOAD_MODE,
    output logic                 RUN_MODE,
    output logic                 OUTPUT_MODE,
    output logic                 SERIAL_VALID,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [GEN_WIDTH-1:0] GENERATION
);

    localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

    seq_state_t state, state_next;
    logic [GEN_WIDTH-1:0] run_len;
    logic [GEN_WIDTH-1:0] generation_q;
    logic bit_tc, run_tc;
    logic start, finish, done_next, accept_load, accept_run;
    logic done_q, serial_valid_q;

    always_comb begin
        state_next  = state;
        done_next   = 1'b0;
        accept_load = 1'b0;
        accept_run  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!CMD_ABORT) begin
                    if (CMD_LOAD) begin
                        state_next  = ST_LOAD;
                        accept_load = 1'b1;
                    end else if (CMD_RUN) begin
                        if (GEN_COUNT != '0) begin
                            state_next = ST_RUN;
                            accept_run = 1'b1;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else if (CMD_OUTPUT) begin
                        state_next = ST_OUTPUT;
                    end
                end
            end
            ST_LOAD: begin
                if (CMD_ABORT) begin
                    state_next = ST_IDLE;
                end else if (bit_tc) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (CMD_ABORT) begin
                    state_next = ST_IDLE;
                end else if (run_tc) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (CMD_ABORT)
                    state_next = ST_IDLE;
                else if (bit_tc)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
                done_next  = !CMD_ABORT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign start  = (state == ST_IDLE) && (state_next != ST_IDLE);
    assign finish = (state != ST_IDLE) && (state_next == ST_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_IDLE;
            done_q         <= 1'b0;
            serial_valid_q <= 1'b0;
            run_len        <= '0;
            generation_q   <= '0;
        end else begin
            state          <= state_next;
            done_q         <= done_next;
            // Memory serial output is registered, so valid trails OUTPUT_MODE by one cycle
            serial_valid_q <= (state == ST_OUTPUT) && !CMD_ABORT;
            if (accept_run)
                run_len <= GEN_COUNT;
            else if (finish)
                run_len <= '0;
            if (accept_load)
                generation_q <= '0;
            else if (state == ST_RUN)
                generation_q <= generation_q + GEN_WIDTH'(1);
        end
    end

    cycle_counter #(.WIDTH(BW)) u_bit_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (finish),
        .load       (start),
        .load_value ('0),
        .enable     (is_transfer(state)),
        .terminal   (BIT_LAST),
        .tc         (bit_tc)
    );

    cycle_counter #(.WIDTH(GEN_WIDTH)) u_run_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (finish),
        .load       (start),
        .load_value ('0),
        .enable     (state == ST_RUN),
        .terminal   (run_len - GEN_WIDTH'(1)),
        .tc         (run_tc)
    );

    assign LOAD_MODE    = (state == ST_LOAD);
    assign RUN_MODE     = (state == ST_RUN);
    assign OUTPUT_MODE  = (state == ST_OUTPUT);
    assign SERIAL_VALID = serial_valid_q;
    assign BUSY         = (state != ST_IDLE);
    assign DONE         = done_q;
    assign GENERATION   = generation_q;

endmodule

// File: tb/tb_system_sequencer.sv
// tb/tb_system_sequencer.sv - self-checking bench for system_sequencer
module tb_system_sequencer;

    localparam int DS = 64;
    localparam int GW = 4;

    // Expected per-cycle outputs: {load, run, output, serial_valid, busy, done}
    typedef struct packed {
        logic lm, rm, om, sv, busy, done;
    } cyc_t;

    localparam cyc_t R_LOAD  = 6'b100010;
    localparam cyc_t R_RUN   = 6'b010010;
    localparam cyc_t R_OUT0  = 6'b001010;
    localparam cyc_t R_OUT   = 6'b001110;
    localparam cyc_t R_DRAIN = 6'b000110;
    localparam cyc_t R_DONE  = 6'b000001;

    typedef struct {
        logic          ld, rn, ot, ab;
        logic [GW-1:0] n;
        logic [5:0]    exp;
    } vec_t;

    logic          CLK, RESET;
    logic          CMD_LOAD, CMD_RUN, CMD_OUTPUT, CMD_ABORT;
    logic [GW-1:0] GEN_COUNT;
    logic          LOAD_MODE, RUN_MODE, OUTPUT_MODE, SERIAL_VALID, BUSY, DONE;
    logic [GW-1:0] GENERATION;

    system_sequencer #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CMD_LOAD     (CMD_LOAD),
        .CMD_RUN      (CMD_RUN),
        .CMD_OUTPUT   (CMD_OUTPUT),
        .CMD_ABORT    (CMD_ABORT),
        .GEN_COUNT    (GEN_COUNT),
        .LOAD_MODE    (LOAD_MODE),
        .RUN_MODE     (RUN_MODE),
        .OUTPUT_MODE  (OUTPUT_MODE),
        .SERIAL_VALID (SERIAL_VALID),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .GENERATION   (GENERATION)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Reference model: a script of future cycles queued when a command is accepted
    cyc_t          script[$];
    cyc_t          cur;
    logic [GW-1:0] exp_gen;

    // Behavioural grid memory: shifts the pattern in, rotates it out through a registered bit
    logic [63:0] pat = 64'hA5A5_0F0F_3C3C_FFFF;
    logic [63:0] mem = '0;
    logic        sout = 1'b0;
    int          load_idx = 0;
    logic [63:0] cap;
    int          capn;

    always @(posedge CLK) begin
        if (LOAD_MODE) begin
            mem      <= {mem[62:0], pat[63 - load_idx]};
            load_idx <= load_idx + 1;
        end else begin
            load_idx <= 0;
            if (OUTPUT_MODE) begin
                sout <= mem[63];
                mem  <= {mem[62:0], mem[63]};
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [5:0] outs();
        return {LOAD_MODE, RUN_MODE, OUTPUT_MODE, SERIAL_VALID, BUSY, DONE};
    endfunction

    task automatic model_step(input logic ld, rn, ot, ab, input logic [GW-1:0] n);
        if (cur.rm)
            exp_gen = exp_gen + GW'(1);
        if (cur.busy) begin
            if (ab)
                script.delete();
        end else if (!ab) begin
            if (ld) begin
                repeat (DS) script.push_back(R_LOAD);
                script.push_back(R_DONE);
                exp_gen = '0;
            end else if (rn) begin
                repeat (int'(n)) script.push_back(R_RUN);
                script.push_back(R_DONE);
            end else if (ot) begin
                script.push_back(R_OUT0);
                repeat (DS - 1) script.push_back(R_OUT);
                script.push_back(R_DRAIN);
                script.push_back(R_DONE);
            end
        end
        cur = (script.size() > 0) ? script.pop_front() : cyc_t'(6'b0);
    endtask

    task automatic tick(input logic ld, rn, ot, ab, input logic [GW-1:0] n);
        CMD_LOAD   = ld;
        CMD_RUN    = rn;
        CMD_OUTPUT = ot;
        CMD_ABORT  = ab;
        GEN_COUNT  = n;
        model_step(ld, rn, ot, ab, n);
        @(posedge CLK);
        #1;
        check("outputs", outs(), cur);
        check("generation", GENERATION, exp_gen);
        check("mode_onehot", $onehot0({LOAD_MODE, RUN_MODE, OUTPUT_MODE}), 1);
        if (SERIAL_VALID) begin
            cap = {cap[62:0], sout};
            capn++;
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int k = 0;
        while (cur.busy && k < max_cycles) begin
            tick(0, 0, 0, 0, '0);
            k++;
        end
        check("wait_idle_busy", BUSY, 0);
    endtask

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 0, 0, 0, 4'd0, R_LOAD};
        tbl[1] = '{1, 1, 0, 0, 4'd5, R_LOAD};
        tbl[2] = '{0, 1, 0, 0, 4'd5, R_RUN};
        tbl[3] = '{0, 1, 0, 0, 4'd0, R_DONE};
        tbl[4] = '{0, 0, 1, 0, 4'd0, R_OUT0};
        tbl[5] = '{1, 0, 0, 1, 4'd0, 6'b0};
        tbl[6] = '{0, 1, 1, 0, 4'd3, R_RUN};
        tbl[7] = '{0, 0, 0, 0, 4'd7, 6'b0};

        RESET = 1'b1;
        {CMD_LOAD, CMD_RUN, CMD_OUTPUT, CMD_ABORT} = 4'b0;
        GEN_COUNT = '0;
        cap = '0;
        capn = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", outs(), 6'b0);
        check("reset_generation", GENERATION, 0);
        RESET = 1'b0;
        cur = '0;
        exp_gen = '0;

        // Load right after reset: LOAD_MODE cycles 1-64, DONE at 65
        tick(1, 0, 0, 0, '0);
        check("load_first_cycle", LOAD_MODE, 1);
        repeat (DS - 1) tick(0, 0, 0, 0, '0);
        check("load_last_cycle", LOAD_MODE, 1);
        tick(0, 0, 0, 0, '0);
        check("load_done", {BUSY, DONE}, 2'b01);
        check("load_generation", GENERATION, 0);

        // Run 5 generations, then GEN_COUNT=0 gives DONE only
        tick(0, 1, 0, 0, 4'd5);
        wait_idle(20);
        check("run5_generation", GENERATION, 5);
        tick(0, 1, 0, 0, 4'd0);
        check("run0_done", {RUN_MODE, BUSY, DONE}, 3'b001);
        tick(0, 0, 0, 0, '0);
        check("run0_generation", GENERATION, 5);

        // Abort at LOAD cycle 10, then a complete reload
        tick(1, 0, 0, 0, '0);
        repeat (9) tick(0, 0, 0, 0, '0);
        check("abort_pre", LOAD_MODE, 1);
        tick(0, 0, 0, 1, '0);
        check("abort_post", {LOAD_MODE, BUSY, DONE}, 3'b000);
        tick(1, 0, 0, 0, '0);
        wait_idle(80);
        check("reload_done", DONE, 1);

        // Load wins over run; run accepted on DONE cycle; output during run ignored
        tick(1, 1, 0, 0, 4'd4);
        check("prio_load", {LOAD_MODE, RUN_MODE}, 2'b10);
        wait_idle(80);
        check("prio_done", DONE, 1);
        tick(0, 1, 0, 0, 4'd3);
        check("b2b_run", RUN_MODE, 1);
        tick(0, 0, 1, 0, '0);
        wait_idle(10);
        check("ignored_output", GENERATION, 3);
        tick(0, 0, 0, 0, '0);
        check("no_queued_output", OUTPUT_MODE, 0);

        // Serial dump must reproduce the loaded pattern
        cap = '0;
        capn = 0;
        tick(0, 0, 1, 0, '0);
        wait_idle(80);
        check("dump_done", DONE, 1);
        check("serial_count", capn, 64);
        check("serial_data", cap, pat);

        // Generation counter wraps silently
        tick(1, 0, 0, 0, '0);
        wait_idle(80);
        tick(0, 1, 0, 0, 4'd15);
        wait_idle(30);
        tick(0, 1, 0, 0, 4'd3);
        wait_idle(10);
        check("gen_wrap", GENERATION, 2);

        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].ld, tbl[i].rn, tbl[i].ot, tbl[i].ab, tbl[i].n);
            check("table_row", outs(), tbl[i].exp);
            tick(0, 0, 0, 1, '0);
            tick(0, 0, 0, 0, '0);
        end

        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            tick(r < 6, r >= 6 && r < 18, r >= 18 && r < 24,
                 $urandom_range(0, 59) == 0, GW'($urandom_range(0, 15)));
        end
        tick(0, 0, 0, 1, '0);
        tick(0, 0, 0, 0, '0);

        // Reset in the middle of a dump clears everything immediately
        tick(0, 0, 1, 0, '0);
        repeat (29) tick(0, 0, 0, 0, '0);
        check("reset_pre", OUTPUT_MODE, 1);
        RESET = 1'b1;
        #1;
        check("reset_mid_outputs", outs(), 6'b0);
        check("reset_mid_generation", GENERATION, 0);
        script.delete();
        cur = '0;
        exp_gen = '0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick(0, 0, 0, 0, '0);
        check("post_reset_idle", BUSY, 0);
        tick(1, 0, 0, 0, '0);
        check("post_reset_accept", LOAD_MODE, 1);
        wait_idle(80);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/system_sequencer.md
SYSTEM_SEQUENCER -- requirements
Module: system_sequencer

Interface
REQ-001 Parameter DATA_SIZE, default 64, SHALL be the grid bits per load/output transfer and match the memory width.
REQ-002 Parameter GEN_WIDTH, default 16, SHALL be the width of the generation request and the generation counter.
REQ-003 CLK  input  1  SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 RESET  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 CMD_LOAD  input  1  SHALL request a serial load of DATA_SIZE bits.
REQ-006 CMD_RUN  input  1  SHALL request GEN_COUNT generations.
REQ-007 CMD_OUTPUT  input  1  SHALL request a serial dump of DATA_SIZE bits.
REQ-008 CMD_ABORT  input  1  SHALL cancel any operation in progress.
REQ-009 GEN_COUNT  input  GEN_WIDTH  SHALL give the generations to run, sampled with CMD_RUN.
REQ-010 LOAD_MODE  output  1  SHALL drive the memory load-mode input.
REQ-011 RUN_MODE  output  1  SHALL drive the memory run-mode input.
REQ-012 OUTPUT_MODE  output  1  SHALL drive the memory output-mode input.
REQ-013 SERIAL_VALID  output  1  SHALL mark cycles in which the memory serial output carries a valid grid bit.
REQ-014 BUSY  output  1  SHALL be high whenever state is not IDLE.
REQ-015 DONE  output  1  SHALL pulse one cycle on normal completion.
REQ-016 GENERATION  output  GEN_WIDTH  SHALL count generations computed since the last accepted load.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, OUTPUT, DRAIN; mode outputs SHALL decode directly from the state register (LOAD_MODE=LOAD, RUN_MODE=RUN, OUTPUT_MODE=OUTPUT).
REQ-018 At most one of LOAD_MODE, RUN_MODE, OUTPUT_MODE SHALL be high in any cycle.
REQ-019 Commands SHALL be sampled only in IDLE; priority CMD_LOAD > CMD_RUN > CMD_OUTPUT; commands outside IDLE SHALL be ignored (no queueing).
REQ-020 Accepted CMD_LOAD: LOAD next cycle, LOAD_MODE high exactly DATA_SIZE consecutive cycles, then IDLE; GENERATION cleared to 0 on acceptance.
REQ-021 Accepted CMD_RUN with GEN_COUNT=N>0: N latched; RUN next cycle, RUN_MODE high exactly N consecutive cycles, then IDLE.
REQ-022 CMD_RUN with GEN_COUNT=0: no state change, no RUN_MODE; DONE SHALL pulse the next cycle.
REQ-023 GENERATION SHALL increment once per RUN_MODE cycle and wrap from 2^GEN_WIDTH-1 to 0 silently.
REQ-024 Accepted CMD_OUTPUT: OUTPUT next cycle, OUTPUT_MODE high exactly DATA_SIZE cycles, then DRAIN for one cycle, then IDLE.
REQ-025 SERIAL_VALID SHALL be high from the second OUTPUT cycle through the DRAIN cycle (exactly DATA_SIZE cycles), accounting for the memory's one-cycle registered serial output.
REQ-026 Transfer bit counter width SHALL be $clog2(DATA_SIZE); terminal count DATA_SIZE-1 SHALL trigger exit.
REQ-027 DONE SHALL be high in the first IDLE cycle after LOAD, RUN or DRAIN; a command presented in that cycle SHALL be accepted (back-to-back operation).
REQ-028 CMD_ABORT in any non-IDLE state SHALL return to IDLE next cycle with all modes and SERIAL_VALID low, counters cleared, no DONE; GENERATION retains its value.
REQ-029 CMD_ABORT in IDLE SHALL have no effect and SHALL take priority over a simultaneous CMD_* there.

Reset
REQ-030 RESET SHALL force state IDLE, bit and run counters 0, GENERATION 0, and all outputs 0 immediately, including mid-operation.
REQ-031 First command SHALL be accepted on the first rising edge after RESET deasserts.

Structure
REQ-032 The state enum typedef and state encoding SHALL live in the shared conway package.
REQ-033 Sub-module cycle_counter (load value, enable, clear, terminal-count flag) SHALL be instantiated for the bit counter and the run counter.
REQ-034 The block SHALL contain no datapath storage; it only sequences the system memory.

Verification
REQ-035 CMD_LOAD at cycle 0 -> LOAD_MODE high cycles 1-64, DONE at 65, BUSY cycles 1-64, GENERATION=0.
REQ-036 CMD_RUN with GEN_COUNT=5 -> RUN_MODE high 5 cycles, DONE next cycle, GENERATION=5; repeat with GEN_COUNT=0 -> DONE only, RUN_MODE never high.
REQ-037 CMD_OUTPUT at cycle 0 -> OUTPUT_MODE cycles 1-64, DRAIN 65, SERIAL_VALID cycles 2-65, DONE at 66; captured serial stream equals previously loaded pattern 0xA5A5_0F0F_3C3C_FFFF.
REQ-038 CMD_ABORT at LOAD cycle 10 -> LOAD_MODE low from cycle 11, no DONE, BUSY low; new CMD_LOAD then completes full 64 cycles.
REQ-039 CMD_LOAD and CMD_RUN together in IDLE -> load performed; CMD_OUTPUT during RUN ignored; CMD_RUN on DONE cycle accepted.
REQ-040 RESET asserted at OUTPUT cycle 30 -> all outputs 0 immediately, IDLE after release; one-hot mode assertion checked throughout.
